// File: rtl/tinyalu_core_if.sv
// TinyALU start/done bus.
// Carries one request (operands, opcode, start) from the requester to the ALU.
// Carries the completion (done pulse, result, err) back to the requester.
// Signal names follow the TinyALU BFM so the interface drops straight into it.
//
// Ports (interface signals):
//   A, B    WIDTH    unsigned operands
//   op      3        opcode
//   start   1        request, held by the requester until done is seen
//   done    1        one-cycle completion pulse
//   result  2*WIDTH  result of the last completed op
//   err     1        illegal-op flag, only ever high together with done
// Modports:
//   master  requester side (BFM / testbench)
//   slave   responder side (tinyalu_core)
interface tinyalu_core_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [2:0]         op;
  logic               start;
  logic               done;
  logic [2*WIDTH-1:0] result;
  logic               err;

  modport master (
    output A,
    output B,
    output op,
    output start,
    input  done,
    input  result,
    input  err
  );

  modport slave (
    input  A,
    input  B,
    input  op,
    input  start,
    output done,
    output result,
    output err
  );
endinterface

// File: rtl/tinyalu_core.sv
// TinyALU responder core.
// Accepts a request when idle and start is high, latching A, B and op at that edge.
// Computes the result and returns it with a registered one-cycle done pulse.
// add/and/xor/no_op/illegal complete one cycle after accept.
// mul completes MUL_LATENCY cycles after accept.
// After done, the core waits for start to drop before it will accept again.
//
// Ports:
//   clk      clock, all state changes on the rising edge
//   reset_n  asynchronous active-low reset
//   bus      tinyalu_core_if.slave: A, B, op, start in; done, result, err out
//
// Parameters:
//   WIDTH        operand width; result is 2*WIDTH bits
//   MUL_LATENCY  accept-to-done cycles for mul; legal range 2..15
module tinyalu_core #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned MUL_LATENCY = 3
) (
  input logic           clk,
  input logic           reset_n,
  tinyalu_core_if.slave bus
);

  localparam logic [2:0] OpNop = 3'b000;
  localparam logic [2:0] OpAdd = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpXor = 3'b011;
  localparam logic [2:0] OpMul = 3'b100;

  // Remaining wait cycles loaded at accept.
  // The exec state fires when the count reaches zero.
  localparam logic [3:0] MulCnt = 4'(MUL_LATENCY - 1);

  // StMul is the execute state for every op.
  // Single-cycle ops enter it with a zero count, so they spend exactly one cycle there.
  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StRelease
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2:0]         op_q;
  logic               accept;
  logic               fire;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic [WIDTH:0]     sum;

  // State register plus operand latch and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OpNop;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
      if (accept) begin
        a_q  <= bus.A;
        b_q  <= bus.B;
        op_q <= bus.op;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    fire    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = StMul;
          cnt_d   = (bus.op == OpMul) ? MulCnt : 4'd0;
        end
      end
      StMul: begin
        if (cnt_q == 4'd0) begin
          fire    = 1'b1;
          state_d = StRelease;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StRelease: begin
        // A held start must not re-execute; wait for it to drop.
        if (!bus.start) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign sum = {1'b0, a_q} + {1'b0, b_q};

  // Output logic: next values of the registered outputs.
  always_comb begin
    done_d   = 1'b0;
    err_d    = 1'b0;
    result_d = result_q;
    if (fire) begin
      done_d = 1'b1;
      case (op_q)
        OpNop: result_d = result_q;
        OpAdd: result_d = {{(WIDTH - 1){1'b0}}, sum};
        OpAnd: result_d = {{WIDTH{1'b0}}, a_q & b_q};
        OpXor: result_d = {{WIDTH{1'b0}}, a_q ^ b_q};
        OpMul: result_d = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
        default: begin
          err_d    = 1'b1;
          result_d = '0;
        end
      endcase
    end
  end

  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.result = result_q;

  // Protocol invariants.
  a_done_not_back_to_back: assert property (
    @(posedge clk) disable iff (!reset_n) done_q |=> !done_q);
  a_err_only_with_done: assert property (
    @(posedge clk) disable iff (!reset_n) err_q |-> done_q);

endmodule

// File: tb/tb_tinyalu_core.sv
module tb_tinyalu_core;

  localparam int unsigned W      = 8;
  localparam int unsigned MUL_LT = 3;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  typedef struct {
    logic [15:0] res;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [15:0] model_last = 16'h0;
  logic [15:0] prev_res = 16'h0;

  tinyalu_core_if #(.WIDTH(W)) alu_if ();

  tinyalu_core #(.WIDTH(W), .MUL_LATENCY(MUL_LT)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (alu_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: what the ALU should return for an op, given the previous result.
  function automatic logic [15:0] ref_result(input int a, input int b, input int o,
                                             input logic [15:0] last);
    case (o)
      0:       return last;
      1:       return 16'(a + b);
      2:       return 16'(a & b);
      3:       return 16'(a ^ b);
      4:       return 16'(a * b);
      default: return 16'h0;
    endcase
  endfunction

  function automatic int ref_latency(input int o);
    return (o == 4) ? MUL_LT : 1;
  endfunction

  // Monitor: pops the scoreboard on every done and checks output rules every cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("err_without_done", {31'b0, alu_if.err & ~alu_if.done}, 32'd0);
      if (!alu_if.done) chk("result_stable", {16'b0, alu_if.result}, {16'b0, prev_res});
      if (alu_if.done) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_done: got done=1, expected none (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("result", {16'b0, alu_if.result}, {16'b0, e.res});
          chk("err", {31'b0, alu_if.err}, {31'b0, e.err});
          chk("done_cycle", cyc, e.cyc);
        end
      end
    end
    prev_res = alu_if.result;
  end

  // Push the expected response for a request that will be accepted at the next edge.
  task automatic expect_op(input int a, input int b, input int o);
    exp_t x;
    x.res      = ref_result(a, b, o, model_last);
    x.err      = (o > 4);
    x.cyc      = cyc + 1 + ref_latency(o);
    model_last = x.res;
    exp_q.push_back(x);
  endtask

  task automatic wait_done();
    bit got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (alu_if.done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      compared++;
      mismatched++;
      $display("FAIL done_timeout: got no done in 40 cycles, expected done");
      exp_q.delete();
    end
  endtask

  // Called #1 after a posedge with the core idle.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o,
                       input int hold_extra, input bit scramble, input bit drop_early);
    alu_if.A     = a;
    alu_if.B     = b;
    alu_if.op    = o;
    alu_if.start = 1'b1;
    expect_op(int'(a), int'(b), int'(o));
    @(posedge clk);
    #1;
    if (scramble) begin
      alu_if.A  = 8'($urandom);
      alu_if.B  = 8'($urandom);
      alu_if.op = 3'($urandom);
    end
    if (drop_early) alu_if.start = 1'b0;
    wait_done();
    repeat (hold_extra) begin
      @(posedge clk);
      #1;
    end
    alu_if.start = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n      = 1'b0;
    alu_if.A     = '0;
    alu_if.B     = '0;
    alu_if.op    = '0;
    alu_if.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_done", {31'b0, alu_if.done}, 32'd0);
    chk("reset_err", {31'b0, alu_if.err}, 32'd0);
    chk("reset_result", {16'b0, alu_if.result}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Carry out, held start, then mul with operand change after accept.
    issue(8'hFF, 8'hFF, 3'b001, 5, 1'b0, 1'b0);
    alu_if.A     = 8'hFF;
    alu_if.B     = 8'hFF;
    alu_if.op    = 3'b100;
    alu_if.start = 1'b1;
    expect_op(255, 255, 4);
    @(posedge clk);
    #1;
    alu_if.A = 8'h00;
    wait_done();
    alu_if.start = 1'b0;
    @(posedge clk);
    #1;

    issue(8'hF0, 8'h3C, 3'b010, 0, 1'b0, 1'b0);
    issue(8'hF0, 8'h3C, 3'b011, 0, 1'b0, 1'b0);
    issue(8'hF0, 8'h3C, 3'b000, 0, 1'b0, 1'b0);
    issue(8'h12, 8'h34, 3'b110, 1, 1'b0, 1'b0);

    // Reset one cycle into a multiply: no done, result cleared.
    alu_if.A     = 8'h10;
    alu_if.B     = 8'h10;
    alu_if.op    = 3'b100;
    alu_if.start = 1'b1;
    @(posedge clk);
    #1;
    reset_n      = 1'b0;
    alu_if.start = 1'b0;
    model_last   = 16'h0;
    #1;
    chk("midmul_reset_result", {16'b0, alu_if.result}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("midmul_result_after", {16'b0, alu_if.result}, 32'd0);
    issue(8'h01, 8'h02, 3'b001, 0, 1'b0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      issue(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), $urandom_range(0, 3),
            1'($urandom), 1'($urandom));
    end

    // Start already high when reset releases.
    reset_n      = 1'b0;
    model_last   = 16'h0;
    alu_if.A     = 8'h05;
    alu_if.B     = 8'h07;
    alu_if.op    = 3'b001;
    alu_if.start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    expect_op(5, 7, 1);
    wait_done();
    alu_if.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/tinyalu_core.md
Name: tinyalu_core

Overview:
Responder end of the TinyALU start/done protocol. It accepts an operation when `start` is high, latches the operands and opcode, computes the result, and returns it with a one-cycle `done` pulse. It is the DUT that sits behind the tinyalu BFM interface. Single-cycle ops finish in one cycle. Multiply has a configurable multi-cycle latency.

Parameters:
- WIDTH, 8: operand width in bits; `result` is 2*WIDTH bits.
- MUL_LATENCY, 3: cycles from accept to `done` for mul_op; legal range 2..15.

Ports:
- clk, input, 1: single clock; all state changes on posedge.
- reset_n, input, 1: asynchronous, active-low reset.
- A, input, WIDTH: operand A, unsigned.
- B, input, WIDTH: operand B, unsigned.
- op, input, 3: opcode. 000 no_op, 001 add_op, 010 and_op, 011 xor_op, 100 mul_op, 101..111 illegal.
- start, input, 1: request; held high by the requester until `done` is seen.
- done, output, 1: one-cycle completion pulse, registered.
- result, output, 2*WIDTH: result of the last completed op, registered.
- err, output, 1: high together with `done` when the accepted op was illegal.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE, done=0, err=0, result=0, mul counter=0.
  - Any in-flight op is discarded; no `done` is produced for it.
- States:
  - IDLE: waits for a request.
  - MUL: multiply pipeline running.
  - RELEASE: waits for `start` to drop before the next request.
- Accept:
  - Occurs at posedge k when state=IDLE and start=1.
  - A, B and op are latched at k.
  - Later changes on A, B, op, or a drop of `start` during execution, are ignored.
- Single-cycle ops (no_op, add, and, xor, illegal):
  - done=1 from posedge k+1 for exactly one cycle; state goes to RELEASE.
  - add: result = zero-extended A+B, carry in bit WIDTH, upper bits 0. Example: 255+255 = 0x01FE.
  - and/xor: bitwise on the low WIDTH bits; upper WIDTH bits = 0.
  - no_op: done pulses; `result` keeps its previous value.
  - illegal op: done=1 and err=1 in the same cycle; result = 0.
- mul_op:
  - IDLE→MUL at k; the counter counts MUL_LATENCY-1 cycles.
  - done=1 and result=A*B (full 2*WIDTH product) from posedge k+MUL_LATENCY for one cycle; then state goes to RELEASE.
- RELEASE:
  - Stays here while start=1, so a held `start` never re-executes.
  - Goes to IDLE at the first posedge with start=0.
  - A new accept needs IDLE, so the minimum gap between dones is 2 cycles for single-cycle ops.
- Output rules:
  - done is never high in two consecutive cycles.
  - err=0 whenever done=0.
  - result changes only on the cycle done rises, or on reset.
- Start dropped in the same cycle done is high: legal; state goes RELEASE→IDLE on the next posedge.
- Reset mid-MUL: done never fires for that op; result=0 after reset; the next accept works normally.
- Start high during reset release: accepted at the first posedge after reset_n=1. This supports the BFM sending immediately after reset without waiting for `done`.

Test Plan:
- Reset with start=0: hold reset_n low 2 cycles → done=0, err=0, result=0x0000, state IDLE.
- add A=0xFF B=0xFF, start held until done → done exactly 1 cycle after accept, result=0x01FE, err=0. Keep start high 5 more cycles → no second done.
- mul A=0xFF B=0xFF with MUL_LATENCY=3 → done at accept+3, result=0xFE01. Change A to 0x00 at accept+1 → result unaffected.
- and A=0xF0 B=0x3C → result=0x0030; then xor same operands → 0x00CC; then no_op → done pulses and result stays 0x00CC.
- op=3'b110 with A=0x12, B=0x34 → done=1 and err=1 in the same cycle, result=0x0000; err low on every other cycle.
- mul A=0x10 B=0x10, assert reset_n low at accept+1 → no done, result=0. Then add 0x01+0x02 after release → result=0x0003 at accept+1.
